// File: rtl/async_fifo_rd_stream.sv
// async_fifo_rd_stream
//   Read-side adapter for the async FIFO, in the rclk domain. It turns the
//   FIFO pop interface (rden / rempty / rdata, with data one cycle after an
//   accepted pop) into a valid/ready stream. A 2-entry prefetch buffer lets the
//   consumer take one word per cycle while m_ready stays high.
//
// Ports
//   rclk, rrst   read clock; asynchronous active-high reset
//   rempty       FIFO empty flag
//   rden         FIFO pop request (combinational)
//   rdata        FIFO read data, valid the cycle after an accepted pop
//   flush        synchronous clear of the buffer and of any in-flight word
//   m_valid      stream valid (buffer not empty)
//   m_ready      consumer ready
//   m_data       stream data (buffer head)
//   occ          buffered word count, 0..2
//   rd_count     stream handshakes since reset, wraps modulo 2^CNT_WIDTH
//   ovf_err      sticky: a word came back while the buffer was full
module async_fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  output logic                  rden,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            occ,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  ovf_err
);

  logic [DATA_WIDTH-1:0] r_buf [2];
  logic                  r_head;
  logic                  r_tail;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_ovf;

  logic       w_pop;
  logic [2:0] w_committed;
  logic       w_cap;
  logic       w_push;
  logic       w_drop;

  assign w_pop       = (r_occ != 2'd0) && m_ready;
  // Buffered words plus the word already requested must fit in two slots;
  // a pop in this cycle frees a slot, which keeps full throughput.
  assign w_committed = {1'b0, r_occ} + {2'b00, r_inflight};
  assign rden        = !rrst && !flush && !rempty && ((w_committed < 3'd2) || w_pop);

  assign w_cap  = r_inflight && !flush;
  // With the buffer full a returning word only fits if the head leaves now.
  assign w_push = w_cap && ((r_occ != 2'd2) || w_pop);
  assign w_drop = w_cap && (r_occ == 2'd2) && !w_pop;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_occ      <= '0;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
    end else if (flush) begin
      // Buffer contents stay; m_valid drops because occupancy is cleared.
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_occ      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= rden;
      if (w_push) begin
        r_buf[r_tail] <= rdata;
        r_tail        <= ~r_tail;
      end
      if (w_pop) begin
        r_head  <= ~r_head;
        r_count <= r_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign m_valid  = (r_occ != 2'd0);
  assign m_data   = r_buf[r_head];
  assign occ      = r_occ;
  assign rd_count = r_count;
  assign ovf_err  = r_ovf;

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
module tb_async_fifo_rd_stream;

  localparam int DW = 32;
  localparam int CW = 5;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          rempty;
  logic          rden;
  logic [DW-1:0] rdata;
  logic          flush;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [1:0]    occ;
  logic [CW-1:0] rd_count;
  logic          ovf_err;

  async_fifo_rd_stream #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .rempty  (rempty),
    .rden    (rden),
    .rdata   (rdata),
    .flush   (flush),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .occ     (occ),
    .rd_count(rd_count),
    .ovf_err (ovf_err)
  );

  always #5 rclk = ~rclk;

  // Reference model: FIFO contents, and the words returned by the FIFO that
  // the stream still owes the consumer, in order. Flush or reset forfeits them.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int unsigned   model_cnt = 0;
  int            n_rden = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          s_rden;
  logic          s_valid;
  logic [DW-1:0] s_data;

  // One rclk cycle: called at posedge+1, drives inputs, samples on negedge,
  // performs the FIFO pop, and returns at the next posedge+1.
  task automatic cycle(input bit rdy, input bit fl);
    bit            got;
    logic [DW-1:0] w;
    logic [DW-1:0] e;
    got     = 1'b0;
    w       = '0;
    m_ready = rdy;
    flush   = fl;
    rempty  = (fifo_q.size() == 0);
    @(negedge rclk);
    s_rden  = rden;
    s_valid = m_valid;
    s_data  = m_data;
    n_cmp++;
    if (rden !== 1'b0 && (rempty || fl)) begin
      n_bad++;
      $display("FAIL rden_gate: rden=%b while rempty=%b flush=%b", rden, rempty, fl);
    end
    if (prev_stall) begin
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== prev_data) begin
        n_bad++;
        $display("FAIL hold: m_valid=%b m_data=%h, required 1 / %h", m_valid, m_data, prev_data);
      end
    end
    n_cmp++;
    if (m_valid !== (occ != 2'd0)) begin
      n_bad++;
      $display("FAIL valid_occ: m_valid=%b occ=%0d", m_valid, occ);
    end
    if (m_valid === 1'b1 && rdy && !fl) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL spurious: m_data=%h delivered, nothing owed", m_data);
      end else begin
        e = exp_q.pop_front();
        if (m_data !== e) begin
          n_bad++;
          $display("FAIL order: m_data=%h, required %h", m_data, e);
        end
      end
      model_cnt++;
    end
    if (fl) exp_q.delete();
    prev_stall = (m_valid === 1'b1) && !rdy && !fl;
    prev_data  = m_data;
    if (rden === 1'b1 && fifo_q.size() != 0) begin
      got = 1'b1;
      w   = fifo_q.pop_front();
      exp_q.push_back(w);
      n_rden++;
    end
    @(posedge rclk);
    #1;
    rdata = got ? w : $urandom;
    n_cmp++;
    if (rd_count !== CW'(model_cnt)) begin
      n_bad++;
      $display("FAIL rd_count: got %0d, required %0d", rd_count, CW'(model_cnt));
    end
  endtask

  task automatic test_reset();
    rrst    = 1'b1;
    m_ready = 1'b0;
    flush   = 1'b0;
    rempty  = 1'b0;
    rdata   = '0;
    #1;
    n_cmp++;
    if (rden !== 1'b0 || m_valid !== 1'b0 || occ !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_ctl: rden=%b m_valid=%b occ=%0d, required 0/0/0", rden, m_valid, occ);
    end
    n_cmp++;
    if (rd_count !== '0 || ovf_err !== 1'b0 || m_data !== '0) begin
      n_bad++;
      $display("FAIL reset_data: rd_count=%0d ovf_err=%b m_data=%h, required 0/0/0", rd_count, ovf_err, m_data);
    end
    @(posedge rclk);
    #1;
    rrst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0);
      n_cmp++;
      if (s_rden !== 1'b0 || s_valid !== 1'b0 || occ !== 2'd0) begin
        n_bad++;
        $display("FAIL idle_empty: rden=%b m_valid=%b occ=%0d, required 0/0/0", s_rden, s_valid, occ);
      end
    end
  endtask

  task automatic test_latency();
    bit            er[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bit            ev[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [DW-1:0] ed[6] = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h0};
    fifo_q.push_back(32'h11);
    fifo_q.push_back(32'h22);
    fifo_q.push_back(32'h33);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0);
      n_cmp++;
      if (s_rden !== er[i] || s_valid !== ev[i]) begin
        n_bad++;
        $display("FAIL latency_c%0d: rden=%b m_valid=%b, required %b/%b", i, s_rden, s_valid, er[i], ev[i]);
      end
      if (ev[i]) begin
        n_cmp++;
        if (s_data !== ed[i]) begin
          n_bad++;
          $display("FAIL latency_data_c%0d: m_data=%h, required %h", i, s_data, ed[i]);
        end
      end
    end
    n_cmp++;
    if (rd_count !== CW'(3)) begin
      n_bad++;
      $display("FAIL latency_count: rd_count=%0d, required 3", rd_count);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w0;
    int            base;
    base = int'(model_cnt);
    for (int i = 0; i < 8; i++) fifo_q.push_back($urandom);
    w0     = fifo_q[0];
    n_rden = 0;
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);
    n_cmp++;
    if (n_rden != 2 || occ !== 2'd2 || m_valid !== 1'b1 || m_data !== w0) begin
      n_bad++;
      $display("FAIL bp_stall: pops=%0d occ=%0d m_valid=%b m_data=%h, required 2/2/1/%h",
               n_rden, occ, m_valid, m_data, w0);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0);
      n_cmp++;
      if (s_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_b2b_%0d: m_valid=%b, required 1", i, s_valid);
      end
    end
    cycle(1'b1, 1'b0);
    n_cmp++;
    if (s_valid !== 1'b0 || rd_count !== CW'(base + 8) || ovf_err !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_done: m_valid=%b rd_count=%0d ovf_err=%b, required 0/%0d/0",
               s_valid, rd_count, ovf_err, CW'(base + 8));
    end
  endtask

  task automatic test_toggle();
    int base;
    base = int'(model_cnt);
    for (int i = 0; i < 16; i++) fifo_q.push_back(32'h100 + i);
    for (int i = 0; i < 48; i++) cycle((i % 2) == 0, 1'b0);
    n_cmp++;
    if (rd_count !== CW'(base + 16) || m_valid !== 1'b0 || ovf_err !== 1'b0) begin
      n_bad++;
      $display("FAIL toggle_done: rd_count=%0d m_valid=%b ovf_err=%b, required %0d/0/0",
               rd_count, m_valid, ovf_err, CW'(base + 16));
    end
  endtask

  task automatic test_flush();
    int base;
    base = int'(model_cnt);
    for (int i = 0; i < 6; i++) fifo_q.push_back($urandom);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    n_cmp++;
    if (occ !== 2'd1 || m_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_pre: occ=%0d m_valid=%b, required 1/1", occ, m_valid);
    end
    // Consumer is ready in the flush cycle: that handshake must not count.
    cycle(1'b1, 1'b1);
    n_cmp++;
    if (s_rden !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_rden: rden=%b, required 0", s_rden);
    end
    n_cmp++;
    if (m_valid !== 1'b0 || occ !== 2'd0) begin
      n_bad++;
      $display("FAIL flush_clear: m_valid=%b occ=%0d, required 0/0", m_valid, occ);
    end
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    n_cmp++;
    if (s_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_drop: m_valid=%b, required 0", s_valid);
    end
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
    n_cmp++;
    if (rd_count !== CW'(base + 4) || ovf_err !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_count: rd_count=%0d ovf_err=%b, required %0d/0", rd_count, ovf_err, CW'(base + 4));
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) fifo_q.push_back($urandom);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
    n_cmp++;
    if (occ !== 2'd1) begin
      n_bad++;
      $display("FAIL rst_pre: occ=%0d, required 1", occ);
    end
    rrst = 1'b1;
    #1;
    n_cmp++;
    if (m_valid !== 1'b0 || occ !== 2'd0 || rd_count !== '0 || rden !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_async: m_valid=%b occ=%0d rd_count=%0d rden=%b, required 0/0/0/0",
               m_valid, occ, rd_count, rden);
    end
    exp_q.delete();
    model_cnt  = 0;
    prev_stall = 1'b0;
    @(posedge rclk);
    #1;
    rrst = 1'b0;
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0);
    n_cmp++;
    if (rd_count !== CW'(6) || ovf_err !== 1'b0 || m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_resume: rd_count=%0d ovf_err=%b m_valid=%b, required 6/0/0", rd_count, ovf_err, m_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 8) fifo_q.push_back($urandom);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
    end
    for (int i = 0; i < 24; i++) cycle(1'b1, 1'b0);
    n_cmp++;
    if (m_valid !== 1'b0 || ovf_err !== 1'b0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL random_done: m_valid=%b ovf_err=%b owed=%0d, required 0/0/0", m_valid, ovf_err, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_toggle();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
